// File: rtl/popeye_rom_arbiter_if.sv
// Bus bundle between the ROM clients, the arbiter and the single-port ROM store.
// master = client/memory side, slave = arbiter side.
interface popeye_rom_arbiter_if #(
  parameter int MEM_AW = 17
);
  logic              dl_en;
  logic              dl_wr;
  logic [MEM_AW-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              cpu_req;
  logic [14:0]       cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic              snd_req;
  logic [13:0]       snd_addr;
  logic              snd_ack;
  logic [7:0]        snd_data;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic              busy;

  modport master (
    output dl_en, dl_wr, dl_addr, dl_data,
    output cpu_req, cpu_addr, snd_req, snd_addr, mem_dout,
    input  cpu_ack, cpu_data, snd_ack, snd_data,
    input  mem_addr, mem_we, mem_re, mem_din, busy
  );

  modport slave (
    input  dl_en, dl_wr, dl_addr, dl_data,
    input  cpu_req, cpu_addr, snd_req, snd_addr, mem_dout,
    output cpu_ack, cpu_data, snd_ack, snd_data,
    output mem_addr, mem_we, mem_re, mem_din, busy
  );
endinterface

// File: rtl/popeye_rom_arbiter.sv
// Shares one ROM store between the download stream (absolute priority) and
// round-robin CPU / sound read clients over a fixed-latency memory.
module popeye_rom_arbiter #(
  parameter int                MEM_AW   = 17,
  parameter int                RD_LAT   = 2,
  parameter logic [MEM_AW-1:0] CPU_BASE = 17'h00000,
  parameter logic [MEM_AW-1:0] SND_BASE = 17'h10000
) (
  input  logic                clk_sys,
  input  logic                reset,
  popeye_rom_arbiter_if.slave bus
);

  // state | meaning
  // IDLE  | no access in progress, arbitrate
  // READ  | mem_re issued, counting down the memory latency
  // DONE  | ack cycle for the granted client
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              gnt_snd_q, gnt_snd_d;
  logic              last_snd_q, last_snd_d;
  logic              pick_snd;
  logic [MEM_AW-1:0] cpu_ext, snd_ext;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [7:0]        cpu_data_q, cpu_data_d;
  logic [7:0]        snd_data_q, snd_data_d;

  assign cpu_ext  = CPU_BASE + MEM_AW'(bus.cpu_addr);
  assign snd_ext  = SND_BASE + MEM_AW'(bus.snd_addr);
  // sound wins only when alone or when the CPU had the previous grant
  assign pick_snd = bus.snd_req & (~bus.cpu_req | ~last_snd_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_snd_q  <= 1'b0;
      last_snd_q <= 1'b1;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_din_q  <= '0;
      cpu_data_q <= '0;
      snd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_snd_q  <= gnt_snd_d;
      last_snd_q <= last_snd_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      mem_din_q  <= mem_din_d;
      cpu_data_q <= cpu_data_d;
      snd_data_q <= snd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_snd_d  = gnt_snd_q;
    last_snd_d = last_snd_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    mem_din_d  = mem_din_q;
    cpu_data_d = cpu_data_q;
    snd_data_d = snd_data_q;

    if (bus.dl_en && bus.dl_wr) begin
      mem_we_d   = 1'b1;
      mem_addr_d = bus.dl_addr;
      mem_din_d  = bus.dl_data;
    end

    if (bus.dl_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cpu_req || bus.snd_req) begin
            gnt_snd_d  = pick_snd;
            mem_addr_d = pick_snd ? snd_ext : cpu_ext;
            mem_re_d   = 1'b1;
            cnt_d      = 3'(RD_LAT);
            state_d    = READ;
          end
        end
        READ: begin
          // cnt_q counts cycles left until mem_dout holds the requested byte
          if (cnt_q == 3'd1) begin
            cnt_d = 3'd0;
          end else if (cnt_q == 3'd0) begin
            if (gnt_snd_q) snd_data_d = bus.mem_dout;
            else           cpu_data_d = bus.mem_dout;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        DONE: begin
          last_snd_d = gnt_snd_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.cpu_ack  = (state_q == DONE) & ~gnt_snd_q;
  assign bus.snd_ack  = (state_q == DONE) &  gnt_snd_q;
  assign bus.cpu_data = cpu_data_q;
  assign bus.snd_data = snd_data_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_re   = mem_re_q;
  assign bus.mem_din  = mem_din_q;
  assign bus.busy     = (state_q != IDLE) | bus.dl_en;

endmodule

// File: tb/tb_popeye_rom_arbiter.sv
// Self-checking bench for popeye_rom_arbiter: directed vectors, multi-cycle
// corner sequences and randomized two-client traffic against a reference model.
module tb_popeye_rom_arbiter;
  localparam int          MEM_AW   = 17;
  localparam int          RD_LAT   = 2;
  localparam logic [16:0] CPU_BASE = 17'h00000;
  localparam logic [16:0] SND_BASE = 17'h10000;
  localparam int          ACC      = RD_LAT + 3;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   passed  = 0;

  always #5 clk_sys = ~clk_sys;

  popeye_rom_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

  popeye_rom_arbiter #(
    .MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .CPU_BASE(CPU_BASE), .SND_BASE(SND_BASE)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [7:0] pattern(input logic [16:0] a);
    return a[7:0] ^ {a[15:9], a[16]} ^ 8'h5A;
  endfunction

  // Behavioural ROM store with RD_LAT-deep read pipeline; junk outside reads.
  logic [7:0] ram   [0:(1<<MEM_AW)-1];
  bit         ram_v [0:(1<<MEM_AW)-1];
  logic [7:0] pipe  [RD_LAT];

  always @(posedge clk_sys) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr]   <= bus.mem_din;
      ram_v[bus.mem_addr] <= 1'b1;
    end
    pipe[0] <= bus.mem_re ? (ram_v[bus.mem_addr] ? ram[bus.mem_addr] : pattern(bus.mem_addr))
                          : 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_dout = pipe[RD_LAT-1];

  // Reference contents: what the bench itself has downloaded, else the pattern.
  logic [7:0] ref_mem [int];
  function automatic logic [7:0] ref_byte(input logic [16:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  always @(negedge clk_sys) begin
    if (!reset) begin
      check("we_re_exclusive", 32'(bus.mem_we & bus.mem_re), 0);
      check("acks_exclusive", 32'(bus.cpu_ack & bus.snd_ack), 0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_ack"},  32'(bus.cpu_ack), 0);
    check({tag, "_snd_ack"},  32'(bus.snd_ack), 0);
    check({tag, "_cpu_data"}, 32'(bus.cpu_data), 0);
    check({tag, "_snd_data"}, 32'(bus.snd_data), 0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    check({tag, "_mem_we"},   32'(bus.mem_we), 0);
    check({tag, "_mem_re"},   32'(bus.mem_re), 0);
    check({tag, "_mem_din"},  32'(bus.mem_din), 0);
    check({tag, "_busy"},     32'(bus.busy), 0);
  endtask

  typedef struct {
    bit          snd;
    logic [14:0] addr;
    logic [16:0] exp_maddr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [6];

  // Starts in an IDLE cycle with no request pending; ends in the following IDLE cycle.
  task automatic single_read(input vec_t v);
    if (v.snd) begin bus.snd_req = 1'b1; bus.snd_addr = v.addr[13:0]; end
    else       begin bus.cpu_req = 1'b1; bus.cpu_addr = v.addr;       end
    tick();
    check("rd_mem_re", 32'(bus.mem_re), 1);
    check("rd_mem_addr", 32'(bus.mem_addr), 32'(v.exp_maddr));
    check("rd_busy", 32'(bus.busy), 1);
    for (int k = 2; k < 2 + RD_LAT; k++) begin
      tick();
      check("rd_no_early_ack", 32'(bus.cpu_ack | bus.snd_ack), 0);
      check("rd_re_pulse", 32'(bus.mem_re), 0);
    end
    tick();
    check("rd_ack", 32'(v.snd ? bus.snd_ack : bus.cpu_ack), 1);
    check("rd_other_ack", 32'(v.snd ? bus.cpu_ack : bus.snd_ack), 0);
    check("rd_data", 32'(v.snd ? bus.snd_data : bus.cpu_data), 32'(v.exp_data));
    bus.cpu_req = 1'b0;
    bus.snd_req = 1'b0;
    tick();
    check("rd_ack_one_cycle", 32'(bus.cpu_ack | bus.snd_ack), 0);
    check("rd_idle_busy", 32'(bus.busy), 0);
    check("rd_data_held", 32'(v.snd ? bus.snd_data : bus.cpu_data), 32'(v.exp_data));
  endtask

  task automatic client(input bit snd, input int n);
    logic [14:0] a;
    logic [16:0] ma;
    int          lat;
    bit          got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 4)) tick();
      a = 15'($urandom);
      if (snd) begin
        a[14] = 1'b0;
        ma = SND_BASE + 17'(a);
        bus.snd_addr = a[13:0];
        bus.snd_req  = 1'b1;
      end else begin
        ma = CPU_BASE + 17'(a);
        bus.cpu_addr = a;
        bus.cpu_req  = 1'b1;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 4 * ACC) begin
        tick();
        lat++;
        got = snd ? bus.snd_ack : bus.cpu_ack;
      end
      check(snd ? "rnd_snd_acked" : "rnd_cpu_acked", 32'(got), 1);
      check(snd ? "rnd_snd_latency" : "rnd_cpu_latency",
            32'(lat >= 2 + RD_LAT && lat <= 2 * ACC), 1);
      check(snd ? "rnd_snd_data" : "rnd_cpu_data",
            32'(snd ? bus.snd_data : bus.cpu_data), 32'(ref_byte(ma)));
      if (snd) bus.snd_req = 1'b0;
      else     bus.cpu_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nack;
    bit          who [4];
    int          at  [4];
    bit          got;
    int          k;
    logic [7:0]  dl_vals [3];

    bus.dl_en = 1'b0; bus.dl_wr = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.snd_req = 1'b0; bus.snd_addr = '0;
    vecs[0] = '{1'b0, 15'h0123, 17'h00123, 8'hA5};
    vecs[1] = '{1'b1, 15'h0010, 17'h10010, 8'h3C};
    vecs[2] = '{1'b0, 15'h7FFF, 17'h07FFF, 8'hC3};
    vecs[3] = '{1'b1, 15'h3FFF, 17'h13FFF, 8'h96};
    vecs[4] = '{1'b0, 15'h0000, 17'h00000, 8'h01};
    vecs[5] = '{1'b1, 15'h0000, 17'h10000, 8'hFE};

    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Preload the vector bytes through the download port.
    bus.dl_en = 1'b1;
    foreach (vecs[i]) begin
      bus.dl_wr   = 1'b1;
      bus.dl_addr = vecs[i].exp_maddr;
      bus.dl_data = vecs[i].exp_data;
      ref_mem[int'(vecs[i].exp_maddr)] = vecs[i].exp_data;
      tick();
      check("dl_we", 32'(bus.mem_we), 1);
      check("dl_addr", 32'(bus.mem_addr), 32'(vecs[i].exp_maddr));
      check("dl_din", 32'(bus.mem_din), 32'(vecs[i].exp_data));
    end
    bus.dl_wr = 1'b0;
    bus.dl_en = 1'b0;
    tick();
    check("dl_we_drop", 32'(bus.mem_we), 0);

    foreach (vecs[i]) single_read(vecs[i]);

    // Tie from reset: CPU first, then strict alternation, ACC cycles apart.
    reset = 1'b1;
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h0123;
    bus.snd_req = 1'b1; bus.snd_addr = 14'h0010;
    reset = 1'b0;
    nack = 0;
    for (int c = 1; c <= 8 * ACC && nack < 4; c++) begin
      tick();
      if (bus.cpu_ack || bus.snd_ack) begin
        who[nack] = bus.snd_ack;
        at[nack]  = c;
        check("alt_data", 32'(bus.snd_ack ? bus.snd_data : bus.cpu_data),
              32'(bus.snd_ack ? ref_byte(17'h10010) : ref_byte(17'h00123)));
        nack++;
        if (nack == 4) begin bus.cpu_req = 1'b0; bus.snd_req = 1'b0; end
      end
    end
    check("alt_count", 32'(nack), 4);
    bus.cpu_req = 1'b0; bus.snd_req = 1'b0;
    for (int i = 0; i < nack; i++) check("alt_order", 32'(who[i]), 32'(i % 2));
    if (nack > 0) check("alt_first_at", 32'(at[0]), 32'(2 + RD_LAT));
    for (int i = 1; i < nack; i++) check("alt_spacing", 32'(at[i] - at[i-1]), 32'(ACC));
    tick();

    // Download preemption of a CPU read in flight.
    dl_vals[0] = 8'h11; dl_vals[1] = 8'h22; dl_vals[2] = 8'h33;
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h0000;
    tick();
    check("pre_mem_re", 32'(bus.mem_re), 1);
    bus.dl_en = 1'b1;
    tick();
    check("pre_no_ack", 32'(bus.cpu_ack), 0);
    check("pre_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 3; i++) begin
      bus.dl_wr   = 1'b1;
      bus.dl_addr = 17'(i);
      bus.dl_data = dl_vals[i];
      ref_mem[i]  = dl_vals[i];
      tick();
      check("pre_we", 32'(bus.mem_we), 1);
      check("pre_addr", 32'(bus.mem_addr), 32'(i));
      check("pre_din", 32'(bus.mem_din), 32'(dl_vals[i]));
      check("pre_no_re", 32'(bus.mem_re), 0);
      check("pre_no_ack_dl", 32'(bus.cpu_ack), 0);
      check("pre_data_kept", 32'(bus.cpu_data), 32'(ref_byte(17'h00123)));
    end
    bus.dl_wr = 1'b0;
    bus.dl_en = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 4 * ACC) begin
      tick();
      k++;
      got = bus.cpu_ack;
      if (k == 1) check("pre_we_end", 32'(bus.mem_we), 0);
    end
    check("pre_regrant_ack", 32'(got), 1);
    check("pre_regrant_at", 32'(k), 32'(2 + RD_LAT));
    check("pre_new_data", 32'(bus.cpu_data), 32'h11);
    bus.cpu_req = 1'b0;
    tick();

    // Synchronous reset in the middle of a sound read.
    bus.snd_req = 1'b1; bus.snd_addr = 14'h0010;
    tick();
    check("rst_mem_re", 32'(bus.mem_re), 1);
    reset = 1'b1;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 4 * ACC) begin
      tick();
      k++;
      got = bus.snd_ack;
      if (bus.cpu_ack) check("rst_stray_cpu_ack", 32'(bus.cpu_ack), 0);
    end
    check("rst_served", 32'(got), 1);
    check("rst_served_at", 32'(k), 32'(2 + RD_LAT));
    check("rst_data", 32'(bus.snd_data), 32'h3C);
    bus.snd_req = 1'b0;
    tick();

    // Stray write strobe without download enable.
    bus.dl_wr = 1'b1; bus.dl_addr = 17'h00005; bus.dl_data = 8'hFF;
    tick();
    check("stray_we", 32'(bus.mem_we), 0);
    check("stray_din", 32'(bus.mem_din), 0);
    check("stray_busy", 32'(bus.busy), 0);
    bus.dl_wr = 1'b0;
    tick();

    fork
      client(1'b0, 60);
      client(1'b1, 60);
    join
    repeat (ACC) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
